// File: rtl/conv_seq_ctrl.sv
// Raster sequencer for the 3-tap Conv1 row accumulator: pixel-memory reads, conv enable, valid/ready output.
// Optional CONV_SEQ_PERF_EN adds perf_cycles/perf_stalls counters.
module conv_seq_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 10
) (
  input  logic              clk_16,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              conv_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_row,
  output logic [7:0]        out_col
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cycles,
  output logic [15:0]       perf_stalls
`endif
);

  localparam int OUT_H = IMG_H - K + 1;
  localparam logic [7:0] LAST_COL      = 8'(IMG_W - 1);
  localparam logic [7:0] LAST_ROW      = 8'(OUT_H - 1);
  localparam logic [7:0] FIRST_OUT_COL = 8'(K - 1);
  localparam logic [7:0] LAST_OUT_COL  = 8'(IMG_W - K);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_r, state_nxt;
  logic [7:0]         col_r, row_r;
  logic [ADDR_W-1:0]  addr_r;
  logic               v1_r;
  logic [7:0]         tag_col_r, tag_row_r;
  logic               out_valid_r;
  logic [7:0]         out_row_r, out_col_r;

  logic stall_s, rd_en_s, conv_en_s, last_rd_s, hs_s, set_ov_s, final_hs_s;

  assign stall_s    = out_valid_r & ~out_ready;
  assign rd_en_s    = (state_r == S_RUN) & ~stall_s;
  assign conv_en_s  = v1_r & ~stall_s;
  assign last_rd_s  = rd_en_s & (row_r == LAST_ROW) & (col_r == LAST_COL);
  assign hs_s       = out_valid_r & out_ready;
  assign set_ov_s   = conv_en_s & (tag_col_r >= FIRST_OUT_COL);
  // Frame ends only once nothing is in flight and the last column has been taken
  assign final_hs_s = (state_r == S_DRAIN) & ~v1_r & hs_s &
                      (out_row_r == LAST_ROW) & (out_col_r == LAST_OUT_COL);

  assign busy      = (state_r == S_RUN) | (state_r == S_DRAIN);
  assign done      = (state_r == S_DONE);
  assign rd_en     = rd_en_s;
  assign rd_addr   = addr_r;
  assign conv_en   = conv_en_s;
  assign out_valid = out_valid_r;
  assign out_row   = out_row_r;
  assign out_col   = out_col_r;

  // State register
  always_ff @(posedge clk_16 or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE:  if (start) state_nxt = S_RUN;   else state_nxt = S_IDLE;
      S_RUN:   if (last_rd_s) state_nxt = S_DRAIN; else state_nxt = S_RUN;
      S_DRAIN: if (final_hs_s) state_nxt = S_DONE; else state_nxt = S_DRAIN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Raster counters advance on every issued read and wrap to zero after the last one
  always_ff @(posedge clk_16 or posedge rst) begin
    if (rst) begin
      col_r  <= 8'd0;
      row_r  <= 8'd0;
      addr_r <= '0;
    end else if (rd_en_s) begin
      if (col_r == LAST_COL) begin
        col_r <= 8'd0;
        if (row_r == LAST_ROW) row_r <= 8'd0;
        else                   row_r <= row_r + 8'd1;
      end else begin
        col_r <= col_r + 8'd1;
      end
      if (last_rd_s) addr_r <= '0;
      else           addr_r <= addr_r + ADDR_W'(1);
    end
  end

  // One-cycle read latency: v1 tracks the returning word and its raster tag
  always_ff @(posedge clk_16 or posedge rst) begin
    if (rst) begin
      v1_r      <= 1'b0;
      tag_col_r <= 8'd0;
      tag_row_r <= 8'd0;
    end else begin
      v1_r <= rd_en_s | (v1_r & stall_s);
      if (rd_en_s) begin
        tag_col_r <= col_r;
        tag_row_r <= row_r;
      end
    end
  end

  // Output result register; priming columns never raise out_valid
  always_ff @(posedge clk_16 or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_row_r   <= 8'd0;
      out_col_r   <= 8'd0;
    end else if (set_ov_s) begin
      out_valid_r <= 1'b1;
      out_row_r   <= tag_row_r;
      out_col_r   <= tag_col_r - FIRST_OUT_COL;
    end else if (hs_s) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic [15:0] perf_cycles_r, perf_stalls_r;

  // Saturating busy/stall counters, cleared when a frame is accepted
  always_ff @(posedge clk_16 or posedge rst) begin
    if (rst) begin
      perf_cycles_r <= 16'd0;
      perf_stalls_r <= 16'd0;
    end else if ((state_r == S_IDLE) && start) begin
      perf_cycles_r <= 16'd0;
      perf_stalls_r <= 16'd0;
    end else begin
      if (busy && (perf_cycles_r != 16'hFFFF))
        perf_cycles_r <= perf_cycles_r + 16'd1;
      if (busy && stall_s && (perf_stalls_r != 16'hFFFF))
        perf_stalls_r <= perf_stalls_r + 16'd1;
    end
  end

  assign perf_cycles = perf_cycles_r;
  assign perf_stalls = perf_stalls_r;
`endif

endmodule
